// File: rtl/ibex_rf_ctx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_ctx_pkg
// Brief    : Shared types for the register-file context mover and its port mux.
// Revision : 1.0
// ============================================================================

package ibex_rf_ctx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SAVE    = 2'd1,
      RESTORE = 2'd2,
      WRFLUSH = 2'd3
   } rf_ctx_state_e;

endpackage

`default_nettype wire

// File: rtl/ibex_rf_ctx_mover.sv
`default_nettype none
// ============================================================================
// Module   : ibex_rf_ctx_mover
// Brief    : Streams registers StartReg..NumRegs-1 out of (save) or into
//            (restore) the flip-flop register file over valid/ready.
// Revision : 1.0
// ============================================================================

module ibex_rf_ctx_mover
   import ibex_rf_ctx_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumRegs   = 32,
   parameter int unsigned StartReg  = 1,
   localparam int unsigned AddrWidth = $clog2(NumRegs)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 save_req_i,
   input  logic                 restore_req_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [AddrWidth-1:0] rf_raddr_o,
   input  logic [DataWidth-1:0] rf_rdata_i,
   output logic [AddrWidth-1:0] rf_waddr_o,
   output logic [DataWidth-1:0] rf_wdata_o,
   output logic                 rf_we_o,
   input  logic                 rf_err_i,
   output logic [DataWidth-1:0] save_data_o,
   output logic                 save_valid_o,
   output logic                 save_last_o,
   input  logic                 save_ready_i,
   input  logic [DataWidth-1:0] restore_data_i,
   input  logic                 restore_valid_i,
   output logic                 restore_ready_o
);

   localparam logic [AddrWidth-1:0] c_first = AddrWidth'(StartReg);
   localparam logic [AddrWidth-1:0] c_last  = AddrWidth'(NumRegs - 1);

   rf_ctx_state_e        r_state, w_state_nxt;
   logic [AddrWidth-1:0] r_idx, w_idx_nxt;
   logic                 r_done, w_done_nxt;
   logic                 r_err, w_err_nxt;
   logic                 r_we, w_we_nxt;
   logic [AddrWidth-1:0] r_waddr, w_waddr_nxt;
   logic [DataWidth-1:0] r_wdata, w_wdata_nxt;
   logic                 w_is_last;

   assign w_is_last = (r_idx == c_last);

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      w_err_nxt   = r_err;
      w_we_nxt    = 1'b0;
      w_waddr_nxt = r_waddr;
      w_wdata_nxt = r_wdata;

      case (r_state)
         IDLE: begin
            // Save has priority; a simultaneous restore request is dropped.
            if (save_req_i) begin
               w_state_nxt = SAVE;
               w_idx_nxt   = c_first;
               w_err_nxt   = 1'b0;
            end else if (restore_req_i) begin
               w_state_nxt = RESTORE;
               w_idx_nxt   = c_first;
               w_err_nxt   = 1'b0;
            end
         end

         SAVE: begin
            if (save_ready_i) begin
               if (w_is_last) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt = r_idx + AddrWidth'(1);
               end
            end
         end

         RESTORE: begin
            if (restore_valid_i) begin
               w_we_nxt    = 1'b1;
               w_waddr_nxt = r_idx;
               w_wdata_nxt = restore_data_i;
               if (w_is_last) begin
                  w_state_nxt = WRFLUSH;
               end else begin
                  w_idx_nxt = r_idx + AddrWidth'(1);
               end
            end
            // An accept in the error cycle still lands; nothing follows it.
            if (rf_err_i) begin
               w_state_nxt = IDLE;
               w_err_nxt   = 1'b1;
            end
         end

         WRFLUSH: begin
            w_state_nxt = IDLE;
            if (rf_err_i) begin
               w_err_nxt = 1'b1;
            end else begin
               w_done_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_idx   <= c_first;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_done  <= w_done_nxt;
         r_err   <= w_err_nxt;
         r_we    <= w_we_nxt;
         r_waddr <= w_waddr_nxt;
         r_wdata <= w_wdata_nxt;
      end
   end

   assign busy_o          = (r_state != IDLE);
   assign done_o          = r_done;
   assign err_o           = r_err;
   assign rf_raddr_o      = (r_state == SAVE) ? r_idx : '0;
   assign rf_waddr_o      = r_waddr;
   assign rf_wdata_o      = r_wdata;
   assign rf_we_o         = r_we;
   assign save_data_o     = rf_rdata_i;
   assign save_valid_o    = (r_state == SAVE);
   assign save_last_o     = (r_state == SAVE) && w_is_last;
   assign restore_ready_o = (r_state == RESTORE);

endmodule

`default_nettype wire
